// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants, types and the arctangent table for the
// cordic rotation engine and the cordic_sched job scheduler.
//   DATA_W / FRAC_W : Q2.16 datapath width and fraction bits
//   GUARD_W         : extra fraction bits carried inside the engine
//   THETA_MAX       : largest accepted |theta|, pi/2 in Q2.16
//   CORDIC_K        : 1/gain start value for x, in Q(FRAC_W+GUARD_W)
//   sched_state_t   : scheduler FSM states
//   atan_lut()      : atan(2^-i) in Q2.16
package cordic_pkg;

  localparam int DATA_W  = 32;
  localparam int FRAC_W  = 16;
  localparam int GUARD_W = 8;

  localparam logic signed [DATA_W-1:0] THETA_MAX = 32'sd102944;

  // 0.6072529351 * 2^24; x starts here so the rotation gain cancels out
  localparam logic signed [DATA_W-1:0] CORDIC_K = 32'sd10188014;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    RESP
  } sched_state_t;

  // atan(2^-i) scaled by 2^FRAC_W; entries past 16 round to zero
  function automatic logic signed [DATA_W-1:0] atan_lut(input int i);
    logic signed [DATA_W-1:0] v;
    case (i)
      0:       v = 32'sd51472;
      1:       v = 32'sd30386;
      2:       v = 32'sd16055;
      3:       v = 32'sd8150;
      4:       v = 32'sd4091;
      5:       v = 32'sd2047;
      6:       v = 32'sd1024;
      7:       v = 32'sd512;
      8:       v = 32'sd256;
      9:       v = 32'sd128;
      10:      v = 32'sd64;
      11:      v = 32'sd32;
      12:      v = 32'sd16;
      13:      v = 32'sd8;
      14:      v = 32'sd4;
      15:      v = 32'sd2;
      16:      v = 32'sd1;
      default: v = 32'sd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic.sv
// cordic: iterative rotation-mode CORDIC engine, one micro-rotation per
// clock. An init pulse loads a new angle; after ITERATIONS clocks the
// outputs hold cos/sin of theta until the next init. No reset: every job
// starts with init, so stale state is never observed.
//   clk     in  1  : clock
//   init    in  1  : load theta and restart the iteration sequence
//   theta   in  32 : signed Q2.16 angle, |theta| <= pi/2 for valid results
//   cos_out out 32 : signed Q2.16 cosine
//   sin_out out 32 : signed Q2.16 sine
module cordic
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = 16
) (
  input  logic                     clk,
  input  logic                     init,
  input  logic signed [DATA_W-1:0] theta,
  output logic signed [DATA_W-1:0] cos_out,
  output logic signed [DATA_W-1:0] sin_out
);

  localparam int STEP_W = $clog2(ITERATIONS + 1);

  logic signed [DATA_W-1:0] x;
  logic signed [DATA_W-1:0] y;
  logic signed [DATA_W-1:0] z;
  logic [STEP_W-1:0]        step;

  // Rotate towards z=0 each cycle, stop once all iterations are done so the
  // result stays put until the scheduler samples it
  always_ff @(posedge clk) begin
    if (init) begin
      x    <= CORDIC_K;
      y    <= '0;
      z    <= theta;
      step <= '0;
    end else if (step != STEP_W'(ITERATIONS)) begin
      if (!z[DATA_W-1]) begin
        x <= x - (y >>> step);
        y <= y + (x >>> step);
        z <= z - atan_lut(int'(step));
      end else begin
        x <= x + (y >>> step);
        y <= y - (x >>> step);
        z <= z + atan_lut(int'(step));
      end
      step <= step + 1'b1;
    end
  end

  // Drop the guard bits to return to Q2.16
  assign cos_out = x >>> GUARD_W;
  assign sin_out = y >>> GUARD_W;

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter. The search starts one
// past last_grant and wraps modulo NUM_REQ; the first active request wins.
//   req        in  NUM_REQ : request vector
//   last_grant in  ID_W    : index granted most recently
//   grant      out NUM_REQ : one-hot grant (all-zero when no request)
//   grant_idx  out ID_W    : encoded index of grant
//   grant_any  out 1       : some request was granted
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  // Walk the requesters in rotated priority order, latching the first hit
  always_comb begin
    int              cand;
    logic [ID_W-1:0] cidx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    cidx      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_grant) + off) % NUM_REQ;
      cidx = ID_W'(cand);
      if (!grant_any && req[cidx]) begin
        grant[cidx] = 1'b1;
        grant_idx   = cidx;
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_sched.sv
// cordic_sched: round-robin scheduler sharing one cordic engine among
// NUM_REQ requesters, one job in flight at a time.
//   clk       in  1          : clock
//   rst_n     in  1          : asynchronous active-low reset
//   req_valid in  NUM_REQ    : per-requester job request
//   req_ready out NUM_REQ    : one-hot grant, only in IDLE
//   req_theta in  NUM_REQ*32 : packed Q2.16 angles, requester i at [32i+31:32i]
//   rsp_valid out 1          : result available
//   rsp_ready in  1          : consumer accepts result
//   rsp_id    out ID_W       : requester index of the result
//   rsp_cos   out 32         : Q2.16 cosine
//   rsp_sin   out 32         : Q2.16 sine
//   rsp_err   out 1          : theta was outside +/-THETA_MAX
//   busy      out 1          : a job is in progress (state != IDLE)
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ITERATIONS = 16,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_theta,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic signed [DATA_W-1:0]    rsp_cos,
  output logic signed [DATA_W-1:0]    rsp_sin,
  output logic                        rsp_err,
  output logic                        busy
);

  localparam int CNT_W = $clog2(ITERATIONS + 1);

  sched_state_t             state;
  logic [CNT_W-1:0]         cnt;
  logic signed [DATA_W-1:0] theta_q;
  logic [ID_W-1:0]          id_q;
  logic                     err_q;
  logic [ID_W-1:0]          last_grant;
  logic                     init;

  logic [NUM_REQ-1:0]       grant;
  logic [ID_W-1:0]          grant_idx;
  logic                     grant_any;
  logic signed [DATA_W-1:0] sel_theta;
  logic                     sel_err;
  logic signed [DATA_W-1:0] cos_out;
  logic signed [DATA_W-1:0] sin_out;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  // The engine only ever sees the latched angle; init marks a fresh job
  cordic #(
    .ITERATIONS (ITERATIONS)
  ) u_cordic (
    .clk     (clk),
    .init    (init),
    .theta   (theta_q),
    .cos_out (cos_out),
    .sin_out (sin_out)
  );

  // Grant is offered only while idle and out of reset, so the arbiter's
  // combinational pick never leaks out during a job or under reset
  assign req_ready = (rst_n && (state == IDLE)) ? grant : '0;

  // Route the granted requester's angle and flag it if out of range
  always_comb begin
    sel_theta = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_theta = req_theta[i*DATA_W +: DATA_W];
    end
    sel_err = (sel_theta > THETA_MAX) || (sel_theta < -THETA_MAX);
  end

  // Job sequencing: accept, pulse init, count out the engine latency,
  // capture the result and hold it until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      theta_q    <= '0;
      id_q       <= '0;
      err_q      <= 1'b0;
      last_grant <= ID_W'(NUM_REQ - 1);
      init       <= 1'b0;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_cos    <= '0;
      rsp_sin    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            theta_q    <= sel_theta;
            id_q       <= grant_idx;
            err_q      <= sel_err;
            last_grant <= grant_idx;
            init       <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          init  <= 1'b0;
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == CNT_W'(ITERATIONS)) begin
            state <= CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAPTURE: begin
          rsp_cos   <= cos_out;
          rsp_sin   <= sin_out;
          rsp_id    <= id_q;
          rsp_err   <= err_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          init  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: scoreboard bench for cordic_sched. Stimulus pushes the
// hand-computed result of each job when it is issued; the monitor pops and
// compares on every response handshake and also watches grant, init and
// backpressure behaviour cycle by cycle.
module tb_cordic_sched;

  localparam int TOL = 16;

  typedef struct {
    int id;
    int cosv;
    int sinv;
    bit err;
    bit chk;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [127:0]       req_theta;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_id;
  logic signed [31:0] rsp_cos;
  logic signed [31:0] rsp_sin;
  logic               rsp_err;
  logic               busy;

  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];
  int   acc_ids[$];
  int   acc_cyc[$];
  int   cyc = 0;
  logic [3:0] hs;
  logic [3:0] sticky;

  cordic_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_theta (req_theta),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_cos   (rsp_cos),
    .rsp_sin   (rsp_sin),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input bit ok, input longint act, input longint exp);
    checks++;
    if (ok) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic bit near(input int a, input int e);
    return (a - e <= TOL) && (e - a <= TOL);
  endfunction

  task automatic toNeg();
    @(negedge clk);
    hs = req_valid & req_ready;
  endtask

  task automatic toPos();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~(hs & ~sticky);
  endtask

  task automatic cycle();
    toNeg();
    toPos();
  endtask

  task automatic pushExp(input int id, input int c, input int s, input bit e, input bit chk);
    exp_t x;
    x.id = id; x.cosv = c; x.sinv = s; x.err = e; x.chk = chk;
    sb.push_back(x);
  endtask

  task automatic waitAccept(input int id, input int budget, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    while (!got && waited < budget) begin
      toNeg();
      got = hs[id];
      toPos();
      waited++;
    end
    checkOutput($sformatf("accept_req%0d", id), got, got, 1);
  endtask

  task automatic applyStimulus(input int id, input int theta, input bit push,
                               input int c, input int s, input bit e, input bit chk);
    int w;
    req_theta[id*32 +: 32] = theta;
    req_valid[id] = 1'b1;
    if (push) pushExp(id, c, s, e, chk);
    waitAccept(id, 100, w);
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < budget) begin
      cycle();
      n++;
    end
    checkOutput("drain", sb.size() == 0, sb.size(), 0);
  endtask

  // Monitor: scoreboard pops on response handshakes plus per-cycle protocol checks
  initial begin
    logic               prev_valid, prev_ready, prev_accept, prev_err;
    logic [1:0]         prev_id;
    logic signed [31:0] prev_cos, prev_sin;
    logic [3:0]         mhs;
    int                 last_acc;
    exp_t               x;
    prev_valid = 0; prev_ready = 0; prev_accept = 0; prev_err = 0;
    prev_id = 0; prev_cos = 0; prev_sin = 0; last_acc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_valid  = 0;
        prev_ready  = 0;
        prev_accept = 0;
      end else begin
        if (busy) checkOutput("no_grant_when_busy", req_ready == 4'b0, req_ready, 0);
        if (dut.init) checkOutput("init_follows_accept", prev_accept, prev_accept, 1);
        if (rsp_valid && prev_valid && !prev_ready) begin
          checkOutput("hold_cos", rsp_cos == prev_cos, rsp_cos, prev_cos);
          checkOutput("hold_sin", rsp_sin == prev_sin, rsp_sin, prev_sin);
          checkOutput("hold_id", rsp_id == prev_id, rsp_id, prev_id);
          checkOutput("hold_err", rsp_err == prev_err, rsp_err, prev_err);
        end
        if (rsp_valid && !prev_valid)
          checkOutput("rsp_latency", (cyc - last_acc) == 20, cyc - last_acc, 20);
        mhs = req_valid & req_ready;
        if (|mhs) begin
          for (int i = 0; i < 4; i++) if (mhs[i]) acc_ids.push_back(i);
          acc_cyc.push_back(cyc);
          last_acc = cyc;
        end
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_rsp", 1'b0, rsp_id, -1);
          end else begin
            x = sb.pop_front();
            checkOutput("rsp_id", rsp_id == x.id[1:0], rsp_id, x.id);
            checkOutput("rsp_err", rsp_err == x.err, rsp_err, x.err);
            if (x.chk) begin
              checkOutput("rsp_cos", near(rsp_cos, x.cosv), rsp_cos, x.cosv);
              checkOutput("rsp_sin", near(rsp_sin, x.sinv), rsp_sin, x.sinv);
            end
          end
        end
        prev_valid  = rsp_valid;
        prev_ready  = rsp_ready;
        prev_cos    = rsp_cos;
        prev_sin    = rsp_sin;
        prev_id     = rsp_id;
        prev_err    = rsp_err;
        prev_accept = |mhs;
      end
    end
  end

  // Stimulus: directed scenarios in sequence
  initial begin
    int base, w, n0, n;
    rst_n = 1'b1;
    req_valid = '0;
    req_theta = '0;
    rsp_ready = 1'b1;
    sticky = '0;
    hs = '0;
    #2;
    rst_n = 1'b0;

    // All four requesters waiting from reset
    req_theta[0*32 +: 32] = 0;
    req_theta[1*32 +: 32] = 51472;
    req_theta[2*32 +: 32] = -51472;
    req_theta[3*32 +: 32] = 0;
    req_valid = 4'b1111;
    repeat (3) cycle();
    toNeg();
    checkOutput("reset_req_ready", req_ready == 4'b0, req_ready, 0);
    checkOutput("reset_rsp_valid", rsp_valid == 1'b0, rsp_valid, 0);
    checkOutput("reset_busy", busy == 1'b0, busy, 0);
    checkOutput("reset_rsp_cos", rsp_cos == 0, rsp_cos, 0);
    checkOutput("reset_rsp_id", rsp_id == 0, rsp_id, 0);
    toPos();
    rst_n = 1'b1;
    pushExp(0, 65536, 0, 0, 1);
    pushExp(1, 46341, 46341, 0, 1);
    pushExp(2, 46341, -46341, 0, 1);
    pushExp(3, 65536, 0, 0, 1);
    base = acc_ids.size();
    toNeg();
    checkOutput("first_grant", req_ready == 4'b0001, req_ready, 1);
    toPos();
    waitDrain(300);
    for (int k = 0; k < 4; k++)
      checkOutput("rr_order", acc_ids[base+k] == k, acc_ids[base+k], k);
    for (int k = 1; k < 4; k++)
      checkOutput("accept_period", acc_cyc[base+k] - acc_cyc[base+k-1] == 21,
                  acc_cyc[base+k] - acc_cyc[base+k-1], 21);

    // Range boundary on requester 1
    applyStimulus(1, 102944, 1, 0, 65536, 0, 1);
    waitDrain(100);
    applyStimulus(1, 102945, 1, 0, 0, 1, 0);
    waitDrain(100);
    applyStimulus(1, -102944, 1, 0, -65536, 0, 1);
    waitDrain(100);

    // Backpressure with requester 2 queued behind
    rsp_ready = 1'b0;
    applyStimulus(0, 0, 1, 65536, 0, 0, 1);
    req_theta[2*32 +: 32] = 51472;
    req_valid[2] = 1'b1;
    pushExp(2, 46341, 46341, 0, 1);
    n = 0;
    toNeg();
    while (!rsp_valid && n < 60) begin
      toPos();
      toNeg();
      n++;
    end
    checkOutput("bp_rsp_seen", rsp_valid, rsp_valid, 1);
    n0 = acc_ids.size();
    for (int k = 0; k < 10; k++) begin
      toPos();
      toNeg();
      checkOutput("bp_valid_held", rsp_valid == 1'b1, rsp_valid, 1);
      checkOutput("bp_no_grant", req_ready == 4'b0, req_ready, 0);
    end
    toPos();
    rsp_ready = 1'b1;
    toNeg();
    checkOutput("bp_no_accepts", acc_ids.size() == n0, acc_ids.size(), n0);
    toPos();
    toNeg();
    checkOutput("bp_next_grant", req_ready == 4'b0100, req_ready, 4);
    checkOutput("bp_idle", busy == 1'b0, busy, 0);
    toPos();
    waitDrain(100);

    // Fairness: req2 always valid, req1 arrives while req2's job runs
    base = acc_ids.size();
    sticky[2] = 1'b1;
    req_theta[2*32 +: 32] = 0;
    req_valid[2] = 1'b1;
    pushExp(2, 65536, 0, 0, 1);
    waitAccept(2, 20, w);
    repeat (5) cycle();
    req_theta[1*32 +: 32] = -51472;
    req_valid[1] = 1'b1;
    pushExp(1, 46341, -46341, 0, 1);
    pushExp(2, 65536, 0, 0, 1);
    waitAccept(1, 60, w);
    sticky[2] = 1'b0;
    waitAccept(2, 60, w);
    waitDrain(100);
    checkOutput("fair_count", acc_ids.size() == base + 3, acc_ids.size() - base, 3);
    checkOutput("fair_first", acc_ids[base] == 2, acc_ids[base], 2);
    checkOutput("fair_req1_next", acc_ids[base+1] == 1, acc_ids[base+1], 1);
    checkOutput("fair_req2_after", acc_ids[base+2] == 2, acc_ids[base+2], 2);
    checkOutput("fair_gap", acc_cyc[base+1] - acc_cyc[base] == 21,
                acc_cyc[base+1] - acc_cyc[base], 21);

    // Reset in the middle of WAIT; the aborted job must never answer
    applyStimulus(0, 51472, 0, 0, 0, 0, 0);
    repeat (6) cycle();
    checkOutput("abort_cnt", dut.cnt == 5, dut.cnt, 5);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_rsp_valid", rsp_valid == 1'b0, rsp_valid, 0);
    checkOutput("abort_busy", busy == 1'b0, busy, 0);
    checkOutput("abort_init", dut.init == 1'b0, dut.init, 0);
    checkOutput("abort_rsp_sin", rsp_sin == 0, rsp_sin, 0);
    checkOutput("abort_rsp_err", rsp_err == 1'b0, rsp_err, 0);
    req_theta[3*32 +: 32] = 0;
    req_valid[3] = 1'b1;
    checkOutput("abort_req_ready", req_ready == 4'b0, req_ready, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    pushExp(3, 65536, 0, 0, 1);
    waitAccept(3, 10, w);
    checkOutput("post_reset_grant_cycle", w == 1, w, 1);
    waitDrain(100);
    repeat (30) cycle();
    checkOutput("scoreboard_empty", sb.size() == 0, sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
